// File: rtl/counter_pkg.sv
// Shared definitions for the reload counter family.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Widest counter the terminal_value helper can describe.
  localparam int TV_MAX_W = 64;

  // Per-cycle mode priority of the counter:
  //   1. latch        : count and reload register take in_value, prescaler
  //                     cleared, tc dropped, any concurrent step discarded.
  //   2. tick         : prescaled step.
  //        count != T : count moves one towards T (modulo 2^WIDTH).
  //        count == T : auto_reload -> reload register,
  //                     else wrap   -> opposite boundary,
  //                     else hold   (one-shot / saturate).
  //   3. otherwise    : hold.
  // T is all ones when counting up and zero when counting down.
  // tc is raised for one cycle when a tick writes a next count equal to T.

  // Terminal value for a WIDTH-bit counter; callers cast to their width.
  function automatic logic [TV_MAX_W-1:0] terminal_value(input logic up, input int width);
    logic [TV_MAX_W-1:0] ones;
    ones = '1;
    if (up == DIR_UP) begin
      terminal_value = ones >> (TV_MAX_W - width);
    end else begin
      terminal_value = '0;
    end
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides step requests: one tick every presc+1 accepted steps.
// Latency: tick is combinational from step and the registered prescale count.
// Backpressure: none; clear wins over step and suppresses the tick.
module step_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               step,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               due;

  // >= rather than == so a presc lowered below the running count still fires.
  assign due  = (presc_cnt >= presc);
  assign tick = step && !clear && due;

  // Prescale count: cleared by clear, advances or restarts on each step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (clear) begin
      presc_cnt <= '0;
    end else if (step) begin
      presc_cnt <= due ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/reload_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate and auto-reload.
// Latency: count and tc update one clock after latch / prescaled step.
// Backpressure: none; latch discards a concurrent step, step=0 holds.
module reload_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PRESC_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               latch,
  input  logic [WIDTH-1:0]   in_value,
  input  logic               step,
  input  logic               up,
  input  logic               auto_reload,
  input  logic               wrap,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               zero,
  output logic               max,
  output logic               tc
);

  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] next_count;
  logic             next_tc;
  logic             tick;

  step_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (latch),
    .step    (step),
    .presc   (presc),
    .tick    (tick)
  );

  assign term = WIDTH'(terminal_value(up, WIDTH));
  assign zero = (count == '0);
  assign max  = (count == '1);

  // Value a tick would write, and whether that write lands on the terminal.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    if (count != term) begin
      next_count = (up == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
      next_tc    = (next_count == term);
    end else if (auto_reload) begin
      next_count = reload_reg;
      next_tc    = (reload_reg == term);
    end else if (wrap) begin
      // Wrapping leaves T for the opposite boundary, so never a tc.
      next_count = (up == DIR_UP) ? '0 : '1;
    end
    // Otherwise saturate: hold at T with no repeated tc.
  end

  // Count, reload register and terminal-count pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= RESET_VALUE;
      reload_reg <= RESET_VALUE;
      tc         <= 1'b0;
    end else if (latch) begin
      count      <= in_value;
      reload_reg <= in_value;
      tc         <= 1'b0;
    end else if (tick) begin
      count      <= next_count;
      tc         <= next_tc;
    end else begin
      tc         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reload_counter.sv
module tb_reload_counter;

  typedef struct packed {
    logic       sel;   // 0: 4-bit instance, 1: 8-bit instance
    logic [7:0] cnt;
    logic       tc;
  } exp_t;

  logic       clock;
  logic       reset_n;

  // 4-bit instance stimulus
  logic       latch, step, up, auto_reload, wrap;
  logic [1:0] presc;
  logic [3:0] in_value;
  logic [3:0] count;
  logic       zero, max, tc;

  // 8-bit instance stimulus
  logic       latch2, step2, up2, auto_reload2, wrap2;
  logic [1:0] presc2;
  logic [7:0] in_value2;
  logic [7:0] count2;
  logic       zero2, max2, tc2;

  exp_t sb[$];
  event chk_now;
  int   checks;
  int   failures;

  reload_counter #(.WIDTH(4), .PRESC_W(2), .RESET_VALUE(4'h0)) dut (
    .clock(clock), .reset_n(reset_n), .latch(latch), .in_value(in_value),
    .step(step), .up(up), .auto_reload(auto_reload), .wrap(wrap),
    .presc(presc), .count(count), .zero(zero), .max(max), .tc(tc)
  );

  reload_counter #(.WIDTH(8), .PRESC_W(2), .RESET_VALUE(8'hA5)) dut2 (
    .clock(clock), .reset_n(reset_n), .latch(latch2), .in_value(in_value2),
    .step(step2), .up(up2), .auto_reload(auto_reload2), .wrap(wrap2),
    .presc(presc2), .count(count2), .zero(zero2), .max(max2), .tc(tc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compares every pending expectation against the selected instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock or chk_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          check("count4", {4'h0, count}, {4'h0, e.cnt[3:0]});
          check("zero4",  {7'h0, zero},  {7'h0, (e.cnt[3:0] == 4'h0)});
          check("max4",   {7'h0, max},   {7'h0, (e.cnt[3:0] == 4'hF)});
          check("tc4",    {7'h0, tc},    {7'h0, e.tc});
        end else begin
          check("count8", count2,        e.cnt);
          check("zero8",  {7'h0, zero2}, {7'h0, (e.cnt == 8'h00)});
          check("max8",   {7'h0, max2},  {7'h0, (e.cnt == 8'hFF)});
          check("tc8",    {7'h0, tc2},   {7'h0, e.tc});
        end
      end
    end
  end

  function automatic exp_t mk(input logic s, input logic [7:0] c, input logic t);
    exp_t e;
    e.sel = s;
    e.cnt = c;
    e.tc  = t;
    return e;
  endfunction

  // One clock on the 4-bit instance: drive at negedge, expect after posedge.
  task automatic cyc(input logic l, input logic s, input logic u, input logic ar,
                     input logic w, input logic [1:0] p, input logic [3:0] v,
                     input logic [3:0] ec, input logic et);
    latch = l; step = s; up = u; auto_reload = ar; wrap = w; presc = p; in_value = v;
    @(posedge clock);
    sb.push_back(mk(1'b0, {4'h0, ec}, et));
    @(negedge clock);
  endtask

  // One clock on the 8-bit instance (down, auto-reload, presc 0).
  task automatic cyc2(input logic s, input logic [7:0] ec, input logic et);
    step = 1'b0; latch = 1'b0;
    step2 = s;
    @(posedge clock);
    sb.push_back(mk(1'b1, ec, et));
    @(negedge clock);
  endtask

  // Expectations checked immediately, independent of the clock.
  task automatic expect_now(input logic [3:0] c4, input logic [7:0] c8);
    sb.push_back(mk(1'b0, {4'h0, c4}, 1'b0));
    sb.push_back(mk(1'b1, c8, 1'b0));
    ->chk_now;
  endtask

  initial begin
    checks = 0; failures = 0;
    latch = 0; step = 0; up = 0; auto_reload = 0; wrap = 0; presc = 0; in_value = 0;
    latch2 = 0; step2 = 0; up2 = 0; auto_reload2 = 1; wrap2 = 0; presc2 = 0; in_value2 = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 expect_now(4'h0, 8'hA5);
    #10 reset_n = 1'b1;
    @(negedge clock);

    // 1: latch 3, count down to zero, then saturate.
    cyc(1,0,0,0,0,2'd0,4'd3, 4'd3,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd2,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd1,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd0,1);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd0,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd0,0);

    // 2: prescaler 2, tick every third step.
    cyc(1,0,0,0,0,2'd2,4'd5, 4'd5,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd5,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd5,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd4,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd4,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd4,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd3,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd3,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd3,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd2,0);
    // presc 3: count reaches 2 without a tick, then presc lowered to 0.
    cyc(0,1,0,0,0,2'd3,4'd0, 4'd2,0);
    cyc(0,1,0,0,0,2'd3,4'd0, 4'd2,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd1,0);
    cyc(0,1,0,0,0,2'd0,4'd0, 4'd0,1);

    // 3: wrap down, wrap up, count up to terminal, saturate up.
    cyc(0,1,0,0,1,2'd0,4'd0,  4'd15,0);
    cyc(0,1,1,0,1,2'd0,4'd0,  4'd0,0);
    cyc(1,0,1,0,1,2'd0,4'd14, 4'd14,0);
    cyc(0,1,1,0,1,2'd0,4'd0,  4'd15,1);
    cyc(0,1,1,0,0,2'd0,4'd0,  4'd15,0);

    // 4: auto-reload timer from 2, including priority over wrap.
    cyc(1,0,0,1,0,2'd0,4'd2, 4'd2,0);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd1,0);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd0,1);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd2,0);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd1,0);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd0,1);
    cyc(0,1,0,1,0,2'd0,4'd0, 4'd2,0);
    cyc(0,1,0,1,1,2'd0,4'd0, 4'd1,0);
    cyc(0,1,0,1,1,2'd0,4'd0, 4'd0,1);
    cyc(0,1,0,1,1,2'd0,4'd0, 4'd2,0);

    // 5a: latch with concurrent step clears the prescaler.
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd2,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd2,0);
    cyc(1,1,0,0,0,2'd2,4'd7, 4'd7,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd7,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd7,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd6,0);

    // 5b: asynchronous reset mid-count (count 9, prescale count 1).
    cyc(1,0,0,0,0,2'd2,4'd9, 4'd9,0);
    cyc(0,1,0,0,0,2'd2,4'd0, 4'd9,0);
    step = 0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 expect_now(4'h0, 8'hA5);
    #5 reset_n = 1'b1;
    @(negedge clock);
    // Prescaler and reload register both cleared: reload yields 0 on third step.
    cyc(0,1,0,1,0,2'd2,4'd0, 4'd0,0);
    cyc(0,1,0,1,0,2'd2,4'd0, 4'd0,0);
    cyc(0,1,0,1,0,2'd2,4'd0, 4'd0,1);

    // 6: 8-bit instance counts down from A5 and reloads A5 without any latch.
    for (int i = 1; i <= 165; i++) begin
      cyc2(1'b1, 8'(165 - i), (i == 165));
    end
    cyc2(1'b1, 8'hA5, 1'b0);
    cyc2(1'b0, 8'hA5, 1'b0);

    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
